// File: rtl/bram_debug_sequencer.sv
// Debug-port master that loads or dumps one CPU BRAM while holding the CPU in reset.
// Define BRAM_DBG_CSUM_EN to enable the transfer checksum on csum; otherwise csum is tied to 0.
module bram_debug_sequencer #(
    parameter int unsigned WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic        start_load,
    input  logic        start_dump,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [31:0] dbg_a2,
    output logic [31:0] dbg_wd2,
    output logic [3:0]  dbg_we2,
    input  logic [31:0] dbg_rd2,
    output logic        busy,
    output logic        done,
    output logic        cpu_rst_hold,
    output logic [31:0] csum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_FLUSH,
        DUMP_ADDR,
        DUMP_CAP,
        DUMP_OUT,
        FINISH
    } state_t;

    localparam logic [12:0] LAST_IDX = 13'(WORDS - 1);

    state_t      state, stateNext;
    logic [12:0] idx, idxNext;
    logic        inReadyR, inReadyNext;
    logic        outValidR, outValidNext;
    logic [31:0] outAddrR, outAddrNext;
    logic [31:0] outDataR, outDataNext;
    logic [31:0] dbgA2R, dbgA2Next;
    logic [31:0] dbgWd2R, dbgWd2Next;
    logic [3:0]  dbgWe2R, dbgWe2Next;
    logic        busyR, busyNext;
    logic        doneR, doneNext;
    logic        loadAccept;

    function automatic logic [31:0] wordAddr(input logic [12:0] i);
        return BASE_ADDR + {17'b0, i, 2'b00};
    endfunction

    assign loadAccept = (state == LOAD) && in_valid && inReadyR;

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        inReadyNext  = inReadyR;
        outValidNext = outValidR;
        outAddrNext  = outAddrR;
        outDataNext  = outDataR;
        dbgA2Next    = dbgA2R;
        dbgWd2Next   = dbgWd2R;
        dbgWe2Next   = '0;
        doneNext     = 1'b0;

        case (state)
            IDLE: begin
                if (start_load) begin
                    stateNext   = LOAD;
                    idxNext     = '0;
                    inReadyNext = 1'b1;
                    dbgA2Next   = BASE_ADDR;
                end else if (start_dump) begin
                    stateNext = DUMP_ADDR;
                    idxNext   = '0;
                    dbgA2Next = BASE_ADDR;
                end
            end
            LOAD: begin
                // The accepted word lands on the port next cycle, so the address is that of the current idx.
                if (loadAccept) begin
                    dbgWe2Next = '1;
                    dbgWd2Next = in_data;
                    dbgA2Next  = wordAddr(idx);
                    idxNext    = idx + 13'd1;
                    if (in_last || idx == LAST_IDX) begin
                        inReadyNext = 1'b0;
                        stateNext   = LOAD_FLUSH;
                    end
                end
            end
            LOAD_FLUSH: begin
                stateNext = FINISH;
                doneNext  = 1'b1;
            end
            DUMP_ADDR: begin
                stateNext = DUMP_CAP;
            end
            DUMP_CAP: begin
                outDataNext  = dbg_rd2;
                outAddrNext  = dbgA2R;
                outValidNext = 1'b1;
                stateNext    = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    outValidNext = 1'b0;
                    if (idx == LAST_IDX) begin
                        stateNext = FINISH;
                        doneNext  = 1'b1;
                    end else begin
                        idxNext   = idx + 13'd1;
                        dbgA2Next = wordAddr(idx + 13'd1);
                        stateNext = DUMP_ADDR;
                    end
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state     <= IDLE;
            idx       <= '0;
            inReadyR  <= 1'b0;
            outValidR <= 1'b0;
            outAddrR  <= '0;
            outDataR  <= '0;
            dbgA2R    <= BASE_ADDR;
            dbgWd2R   <= '0;
            dbgWe2R   <= '0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
        end else begin
            state     <= stateNext;
            idx       <= idxNext;
            inReadyR  <= inReadyNext;
            outValidR <= outValidNext;
            outAddrR  <= outAddrNext;
            outDataR  <= outDataNext;
            dbgA2R    <= dbgA2Next;
            dbgWd2R   <= dbgWd2Next;
            dbgWe2R   <= dbgWe2Next;
            busyR     <= busyNext;
            doneR     <= doneNext;
        end
    end

`ifdef BRAM_DBG_CSUM_EN
    logic [31:0] csumR, csumNext;

    always_comb begin
        csumNext = csumR;
        if (state == IDLE && (start_load || start_dump)) begin
            csumNext = '0;
        end else if (loadAccept) begin
            csumNext = csumR + in_data;
        end else if (state == DUMP_CAP) begin
            csumNext = csumR + dbg_rd2;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            csumR <= '0;
        end else begin
            csumR <= csumNext;
        end
    end

    assign csum = csumR;
`else
    assign csum = '0;
`endif

    assign in_ready     = inReadyR;
    assign out_valid    = outValidR;
    assign out_addr     = outAddrR;
    assign out_data     = outDataR;
    assign dbg_a2       = dbgA2R;
    assign dbg_wd2      = dbgWd2R;
    assign dbg_we2      = dbgWe2R;
    assign busy         = busyR;
    assign done         = doneR;
    assign cpu_rst_hold = busyR;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Bench for bram_debug_sequencer: start-vector table, directed load/dump sequences and a
// randomized load/dump loop checked against an array model of the BRAM contents.
module tb_bram_debug_sequencer;

    localparam int unsigned WORDS = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic        start_load, start_dump;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_addr, out_data;
    logic [31:0] dbg_a2, dbg_wd2, dbg_rd2;
    logic [3:0]  dbg_we2;
    logic        busy, done, cpu_rst_hold;
    logic [31:0] csum;

    bram_debug_sequencer #(.WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
        .start_load(start_load), .start_dump(start_dump),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
        .busy(busy), .done(done), .cpu_rst_hold(cpu_rst_hold), .csum(csum)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // BRAM model with synchronous read, byte write enables
    logic [31:0] mem [0:15];
    logic [31:0] rdReg = '0;
    assign dbg_rd2 = rdReg;
    always @(posedge CPU_CLK) begin
        for (int b = 0; b < 4; b++)
            if (dbg_we2[b]) mem[dbg_a2[5:2]][8*b +: 8] <= dbg_wd2[8*b +: 8];
        rdReg <= mem[dbg_a2[5:2]];
    end

    always @(posedge CPU_CLK) cyc <= cyc + 1;

    // reference contents of the BRAM as the spec says it should be
    logic [31:0] expMem [0:3];

    logic [63:0] wrQ[$];
    int          wrCyc[$];
    logic [31:0] accQ[$];
    int          accCyc[$];
    logic [63:0] dumpQ[$];
    int          dumpCyc[$];
    int          doneCnt = 0;
    int          doneCyc = 0;
    int          weDumpCnt = 0;
    bit          dumpPhase = 0;
    logic        prevV = 0, prevR = 0;
    logic [31:0] prevA = '0, prevD = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expCsum(input logic [31:0] s);
`ifdef BRAM_DBG_CSUM_EN
        return s;
`else
        return 32'h0;
`endif
    endfunction

    always @(negedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            prevV = 1'b0;
        end else begin
            if (prevV && !prevR) begin
                check("hold_valid", out_valid, 1);
                check("hold_addr", out_addr, prevA);
                check("hold_data", out_data, prevD);
            end
            if (in_valid && in_ready) begin
                accQ.push_back(in_data);
                accCyc.push_back(cyc);
            end
            if (dbg_we2 != 4'h0) begin
                wrQ.push_back({dbg_a2, dbg_wd2});
                wrCyc.push_back(cyc);
                if (dumpPhase) weDumpCnt++;
            end
            if (out_valid && out_ready) begin
                dumpQ.push_back({out_addr, out_data});
                dumpCyc.push_back(cyc);
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            prevV = out_valid;
            prevR = out_ready;
            prevA = out_addr;
            prevD = out_data;
        end
    end

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic clearQ();
        wrQ.delete(); wrCyc.delete(); accQ.delete(); accCyc.delete();
        dumpQ.delete(); dumpCyc.delete();
        doneCnt = 0;
        weDumpCnt = 0;
    endtask

    task automatic doReset();
        CPU_RST_N = 1'b0;
        tick();
        tick();
        CPU_RST_N = 1'b1;
        tick();
    endtask

    task automatic pulseLoad();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] d, input logic last, input bit gaps);
        bit acc = 0;
        in_data = d;
        in_last = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("load_accept_timeout", acc, 1);
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 64 && busy; i++) tick();
        check(name, busy, 0);
    endtask

    task automatic runDump(input int mode);
        clearQ();
        dumpPhase = 1;
        out_ready = (mode == 0);
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        for (int i = 0; i < 300 && busy; i++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc / 2) % 2) == 1;
                default: out_ready = $urandom_range(0, 1) == 1;
            endcase
            tick();
        end
        out_ready = 1'b0;
        dumpPhase = 0;
        check("dump_idle", busy, 0);
    endtask

    task automatic checkDump(input string name);
        logic [31:0] s = '0;
        check({name, "_count"}, dumpQ.size(), WORDS);
        for (int unsigned i = 0; i < WORDS; i++) begin
            s += expMem[i];
            if (i < dumpQ.size())
                check($sformatf("%s_word%0d", name, i), dumpQ[i], {BASE + 32'(4 * i), expMem[i]});
        end
        check({name, "_done"}, doneCnt, 1);
        check({name, "_no_write"}, weDumpCnt, 0);
        check({name, "_csum"}, csum, expCsum(s));
    endtask

    typedef struct {
        logic sl;
        logic sd;
        logic expBusy;
        logic expReady;
        logic expValid3;
    } vec_t;

    initial begin
        vec_t        tbl [4];
        logic [31:0] w [0:3];
        logic [31:0] s;
        int          firstLow;
        int          n;
        bit          useLast;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) expMem[i] = '0;
        CPU_RST_N = 1'b0;
        start_load = 0; start_dump = 0; in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;

        // reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_we2", dbg_we2, 0);
        check("rst_wd2", dbg_wd2, 0);
        check("rst_a2", dbg_a2, BASE);
        check("rst_hold", cpu_rst_hold, 0);
        check("rst_csum", csum, 0);

        // start pulse response table
        for (int i = 0; i < 4; i++) begin
            doReset();
            start_load = tbl[i].sl;
            start_dump = tbl[i].sd;
            tick();
            start_load = 1'b0;
            start_dump = 1'b0;
            check($sformatf("vec%0d_busy", i), busy, tbl[i].expBusy);
            check($sformatf("vec%0d_hold", i), cpu_rst_hold, tbl[i].expBusy);
            check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].expReady);
            tick();
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].expValid3);
            check($sformatf("vec%0d_we2", i), dbg_we2, 0);
        end
        doReset();

        // load 4 words back-to-back, in_last on the 4th
        clearQ();
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        pulseLoad();
        for (int i = 0; i < 4; i++) sendWord(w[i], i == 3, 0);
        waitIdle("load1_idle");
        check("load1_writes", wrQ.size(), 4);
        for (int i = 0; i < 4 && i < wrQ.size() && i < accCyc.size(); i++) begin
            check($sformatf("load1_wr%0d", i), wrQ[i], {BASE + 32'(4 * i), w[i]});
            check($sformatf("load1_wr%0d_cyc", i), wrCyc[i], accCyc[i] + 1);
            expMem[i] = w[i];
        end
        if (wrCyc.size() == 4) check("load1_consecutive", wrCyc[3] - wrCyc[0], 3);
        check("load1_done_cnt", doneCnt, 1);
        if (accCyc.size() == 4) check("load1_done_delay", doneCyc - accCyc[3], 2);
        check("load1_hold", cpu_rst_hold, 0);
        check("load1_csum", csum, expCsum(32'hAA));

        // dump with consumer always ready: one word per 3 cycles
        runDump(0);
        checkDump("dump_ready");
        for (int i = 0; i + 1 < dumpCyc.size(); i++)
            check($sformatf("dump_rate%0d", i), dumpCyc[i + 1] - dumpCyc[i], 3);

        // dump with consumer toggling every 2 cycles
        runDump(1);
        checkDump("dump_toggle");

        // simultaneous starts pick load; a start_dump during the load is ignored
        clearQ();
        start_load = 1'b1;
        start_dump = 1'b1;
        tick();
        start_load = 1'b0;
        start_dump = 1'b0;
        check("both_in_ready", in_ready, 1);
        sendWord(32'h55, 0, 0);
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        sendWord(32'h66, 1, 0);
        waitIdle("both_idle");
        repeat (10) tick();
        check("both_no_dump", dumpQ.size(), 0);
        check("both_out_valid", out_valid, 0);
        check("both_busy", busy, 0);
        check("both_writes", wrQ.size(), 2);
        check("both_csum", csum, expCsum(32'h55 + 32'h66));
        expMem[0] = 32'h55;
        expMem[1] = 32'h66;

        // reset in the middle of a load after 2 words have been written
        clearQ();
        pulseLoad();
        sendWord(32'hA0, 0, 0);
        sendWord(32'hA1, 0, 0);
        tick();
        in_valid = 1'b1;
        in_data  = 32'hA2;
        #2;
        CPU_RST_N = 1'b0;
        #1;
        check("abort_we2", dbg_we2, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_hold", cpu_rst_hold, 0);
        check("abort_csum", csum, 0);
        tick();
        in_valid = 1'b0;
        tick();
        CPU_RST_N = 1'b1;
        tick();
        expMem[0] = 32'hA0;
        expMem[1] = 32'hA1;
        check("abort_writes", wrQ.size(), 2);
        check("abort_mem0", mem[0], expMem[0]);
        check("abort_mem1", mem[1], expMem[1]);
        check("abort_mem2", mem[2], expMem[2]);

        // 6 words offered without in_last: only WORDS are taken
        clearQ();
        pulseLoad();
        firstLow = -1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 6);
            in_data  = 32'hB0 + 32'(k);
            if (!in_ready && firstLow < 0) firstLow = cyc;
            tick();
        end
        in_valid = 1'b0;
        waitIdle("ovf_idle");
        check("ovf_accepts", accQ.size(), 4);
        check("ovf_writes", wrQ.size(), 4);
        if (accCyc.size() == 4) check("ovf_ready_drop", firstLow, accCyc[3] + 1);
        for (int i = 0; i < 4; i++) expMem[i] = 32'hB0 + 32'(i);
        if (wrQ.size() == 4) check("ovf_last_write", wrQ[3], {BASE + 32'hC, expMem[3]});
        check("ovf_csum", csum, expCsum(32'hB0 + 32'hB1 + 32'hB2 + 32'hB3));

        // randomized loads of 1..WORDS words followed by random-backpressure dumps
        for (int it = 0; it < 6; it++) begin
            clearQ();
            n = $urandom_range(1, 4);
            useLast = (n < 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
            s = '0;
            pulseLoad();
            for (int i = 0; i < n; i++) begin
                w[i] = $urandom;
                sendWord(w[i], useLast && (i == n - 1), 1);
                expMem[i] = w[i];
                s += w[i];
            end
            waitIdle($sformatf("rnd%0d_idle", it));
            check($sformatf("rnd%0d_writes", it), wrQ.size(), n);
            for (int i = 0; i < n && i < wrQ.size(); i++)
                check($sformatf("rnd%0d_wr%0d", it, i), wrQ[i], {BASE + 32'(4 * i), w[i]});
            check($sformatf("rnd%0d_done", it), doneCnt, 1);
            check($sformatf("rnd%0d_csum", it), csum, expCsum(s));
            runDump(2);
            checkDump($sformatf("rnd%0d_dump", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
